ysyx_25020047_ctrl: RTL and testbench
=====================================

YSYX_25020047_CTRL -- requirements
Module: ysyx_25020047_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd255: maximum wait cycles in FETCH or MEM before the error state.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ifu_req_valid  out  1  instruction fetch request.
REQ-005 SHALL have port ifu_req_ready  in  1  fetch request accepted.
REQ-006 SHALL have port ifu_rvalid  in  1  fetched instruction valid.
REQ-007 SHALL have port inst_latch_en  out  1  one-cycle pulse to capture the instruction word.
REQ-008 SHALL have ports is_load, is_store, is_ecall, is_ebreak, is_csr, rd_wr  in  1 each  decoded class flags, valid in EXEC through WB.
REQ-009 SHALL have port lsu_req_valid  out  1  memory access request.
REQ-010 SHALL have port lsu_wen  out  1  equals is_store while lsu_req_valid=1, else 0.
REQ-011 SHALL have port lsu_req_ready  in  1  memory request accepted.
REQ-012 SHALL have port lsu_done  in  1  load data or store completion.
REQ-013 SHALL have ports rf_wen, csr_wen, trap_en, pc_wen  out  1 each  writeback strobes.
REQ-014 SHALL have ports state  out  3, retired  out  32, halted  out  1, err  out  1.

Function
REQ-015 SHALL use these state encodings: FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4, ERR=5.
REQ-016 FETCH SHALL hold ifu_req_valid=1 until the first cycle with ifu_req_ready=1, then drop it and wait for ifu_rvalid.
REQ-017 FETCH SHALL ignore ifu_rvalid unless the request has been accepted in an earlier cycle.
REQ-018 On an accepted ifu_rvalid, the controller SHALL pulse inst_latch_en for that cycle and enter EXEC next cycle.
REQ-019 EXEC SHALL last exactly 1 cycle, with next state by priority: is_ebreak->HALT; is_load|is_store->MEM; otherwise->WB.
REQ-020 MEM SHALL hold lsu_req_valid=1 until lsu_req_ready=1, then wait for lsu_done, then go to WB.
REQ-021 In MEM, lsu_done SHALL be ignored until after the request is accepted.
REQ-022 If lsu_req_ready and lsu_done are both high in the same cycle, only the handshake SHALL count, and lsu_done SHALL be required on a later cycle.
REQ-023 WB SHALL last exactly 1 cycle with strobes pc_wen=1, rf_wen=rd_wr, csr_wen=is_csr, trap_en=is_ecall.
REQ-024 In WB, retired SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, and the next state SHALL be FETCH.
REQ-025 Strobes SHALL be 0 in every state other than WB.
REQ-026 Minimum instruction latency SHALL be 4 cycles (non-memory: FETCH with ready and rvalid on consecutive cycles, EXEC, WB).
REQ-027 A 16-bit watchdog SHALL clear on entry to FETCH or MEM and increment on every cycle spent in those states.
REQ-028 When the watchdog equals TIMEOUT while still waiting, the next state SHALL be ERR.
REQ-029 A completing handshake in the same cycle as the watchdog reaching TIMEOUT SHALL win.
REQ-030 HALT SHALL be sticky until reset: halted=1, all requests and strobes 0, retired frozen.
REQ-031 ERR SHALL be sticky until reset: err=1, all requests and strobes 0, retired frozen.
REQ-032 state, halted and err SHALL be registered outputs; request and strobe outputs SHALL decode combinationally from state and inputs.

Reset
REQ-033 On rst_n=0, asynchronously: state=FETCH, retired=0, watchdog=0, request-accepted flags=0, halted=0, err=0.
REQ-034 During reset all outputs except ifu_req_valid SHALL be 0, and ifu_req_valid SHALL be 0 while rst_n=0.
REQ-035 Reset asserted in any state, including mid-handshake, SHALL abandon the transaction.
REQ-036 On the first cycle after rst_n releases, the controller SHALL issue ifu_req_valid=1.

Verification
REQ-037 Scenario, ALU instruction: ifu_req_ready=1 in cycle 1, ifu_rvalid=1 in cycle 2, rd_wr=1 -> EXEC in cycle 3, WB in cycle 4 with rf_wen=pc_wen=1, retired=1, FETCH in cycle 5.
REQ-038 Scenario, load: is_load=1, lsu_req_ready after 2 cycles, lsu_done 3 cycles later -> lsu_wen=0 throughout, WB strobes rf_wen, retired increments once.
REQ-039 Scenario, ecall then ebreak: ecall -> trap_en=1 and pc_wen=1 in WB; ebreak -> HALT with state=4 and halted=1, no further ifu_req_valid, retired unchanged.
REQ-040 Scenario, watchdog with TIMEOUT=8: ifu_req_ready held low -> ERR after 8 FETCH cycles, err=1; the same case with ready arriving on cycle 8 -> no error.
REQ-041 Scenario, reset mid-operation: rst_n pulsed low mid-MEM with lsu_req_valid=1 -> immediately state=0, retired=0, lsu_req_valid=0; fetch restarts after release.
REQ-042 Scenario, counter wrap: retired preloaded to 0xFFFFFFFF via force -> after one WB, retired=0x00000000.

Source files
------------

// File: rtl/ysyx_25020047_ctrl.sv
// ysyx_25020047_ctrl -- multi-cycle instruction sequencing controller.
//
// Steps each instruction through FETCH -> EXEC -> (MEM) -> WB, handshaking
// with the fetch unit and the load/store unit. A 16-bit watchdog bounds the
// wait in FETCH and MEM. HALT (ebreak) and ERR (watchdog expiry) are sticky
// until reset.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ifu_req_valid/ifu_req_ready     fetch request handshake
//   ifu_rvalid, inst_latch_en       fetched word valid / capture pulse
//   is_load..rd_wr                  decoded class flags (valid EXEC..WB)
//   lsu_req_valid/lsu_req_ready     memory request handshake
//   lsu_wen, lsu_done               store select / access completion
//   rf_wen, csr_wen, trap_en, pc_wen  writeback strobes (WB only)
//   state, retired, halted, err     status (registered)
module ysyx_25020047_ctrl #(
   parameter logic [15:0] TIMEOUT = 16'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_rvalid,
   output logic        inst_latch_en,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_ecall,
   input  logic        is_ebreak,
   input  logic        is_csr,
   input  logic        rd_wr,
   output logic        lsu_req_valid,
   output logic        lsu_wen,
   input  logic        lsu_req_ready,
   input  logic        lsu_done,
   output logic        rf_wen,
   output logic        csr_wen,
   output logic        trap_en,
   output logic        pc_wen,
   output logic [2:0]  state,
   output logic [31:0] retired,
   output logic        halted,
   output logic        err
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_ifu_acc;   // fetch request accepted, now waiting for rvalid
   logic        r_lsu_acc;   // memory request accepted, now waiting for done
   logic [15:0] r_wdog;
   logic [31:0] r_retired;
   logic        r_halted;
   logic        r_err;

   logic        w_in_fetch;
   logic        w_in_mem;
   logic        w_in_wb;
   logic        w_ifu_hs;
   logic        w_ifu_done;
   logic        w_lsu_hs;
   logic        w_lsu_fin;
   logic [15:0] w_wdog_inc;
   logic        w_timeout;

   assign w_in_fetch = (r_state == S_FETCH);
   assign w_in_mem   = (r_state == S_MEM);
   assign w_in_wb    = (r_state == S_WB);

   // Response strobes only count once the request was accepted in an
   // earlier cycle, so a same-cycle ready+rvalid/done is just the handshake.
   assign w_ifu_hs   = w_in_fetch && !r_ifu_acc && ifu_req_ready;
   assign w_ifu_done = w_in_fetch &&  r_ifu_acc && ifu_rvalid;
   assign w_lsu_hs   = w_in_mem   && !r_lsu_acc && lsu_req_ready;
   assign w_lsu_fin  = w_in_mem   &&  r_lsu_acc && lsu_done;

   // The watchdog value including the current cycle; any progress made in
   // the cycle it reaches TIMEOUT takes precedence over the error.
   assign w_wdog_inc = r_wdog + 16'd1;
   assign w_timeout  = (w_in_fetch || w_in_mem) && (w_wdog_inc == TIMEOUT) &&
                       !(w_ifu_hs || w_ifu_done || w_lsu_hs || w_lsu_fin);

   // Requests and strobes decode combinationally; rst_n gates the fetch
   // request because the reset state itself is FETCH.
   assign ifu_req_valid = rst_n && w_in_fetch && !r_ifu_acc;
   assign inst_latch_en = w_ifu_done;
   assign lsu_req_valid = w_in_mem && !r_lsu_acc;
   assign lsu_wen       = lsu_req_valid && is_store;
   assign pc_wen        = w_in_wb;
   assign rf_wen        = w_in_wb && rd_wr;
   assign csr_wen       = w_in_wb && is_csr;
   assign trap_en       = w_in_wb && is_ecall;

   assign state   = r_state;
   assign retired = r_retired;
   assign halted  = r_halted;
   assign err     = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_ifu_acc <= 1'b0;
         r_lsu_acc <= 1'b0;
         r_wdog    <= 16'd0;
         r_retired <= 32'd0;
         r_halted  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_wdog <= w_wdog_inc;
               if (w_ifu_done) begin
                  r_state   <= S_EXEC;
                  r_ifu_acc <= 1'b0;
               end else if (w_timeout) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else if (w_ifu_hs) begin
                  r_ifu_acc <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_ebreak) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (is_load || is_store) begin
                  r_state   <= S_MEM;
                  r_wdog    <= 16'd0;
                  r_lsu_acc <= 1'b0;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               r_wdog <= w_wdog_inc;
               if (w_lsu_fin) begin
                  r_state   <= S_WB;
                  r_lsu_acc <= 1'b0;
               end else if (w_timeout) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else if (w_lsu_hs) begin
                  r_lsu_acc <= 1'b1;
               end
            end
            S_WB: begin
               r_retired <= r_retired + 32'd1;
               r_state   <= S_FETCH;
               r_wdog    <= 16'd0;
               r_ifu_acc <= 1'b0;
            end
            S_HALT, S_ERR: begin
               r_state <= r_state;
            end
            default: begin
               // Unused encodings are treated as a fault.
               r_state <= S_ERR;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_ctrl.sv
// Self-checking bench for ysyx_25020047_ctrl: directed instruction sequences,
// with writeback expectations queued by the stimulus and checked by a
// separate monitor whenever the controller presents a WB cycle (pc_wen=1).
module tb_ysyx_25020047_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_rvalid, inst_latch_en;
   logic        is_load, is_store, is_ecall, is_ebreak, is_csr, rd_wr;
   logic        lsu_req_valid, lsu_wen, lsu_req_ready, lsu_done;
   logic        rf_wen, csr_wen, trap_en, pc_wen;
   logic [2:0]  state;
   logic [31:0] retired;
   logic        halted, err;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        rf;
      logic        csr;
      logic        trap;
      logic [31:0] ret;
   } wb_t;

   wb_t         exp_q[$];
   logic [31:0] exp_ret;

   always #5 clk = ~clk;

   ysyx_25020047_ctrl #(.TIMEOUT(16'd8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rvalid(ifu_rvalid), .inst_latch_en(inst_latch_en),
      .is_load(is_load), .is_store(is_store), .is_ecall(is_ecall),
      .is_ebreak(is_ebreak), .is_csr(is_csr), .rd_wr(rd_wr),
      .lsu_req_valid(lsu_req_valid), .lsu_wen(lsu_wen),
      .lsu_req_ready(lsu_req_ready), .lsu_done(lsu_done),
      .rf_wen(rf_wen), .csr_wen(csr_wen), .trap_en(trap_en), .pc_wen(pc_wen),
      .state(state), .retired(retired), .halted(halted), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every WB cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && pc_wen) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL wb_unexpected got=pc_wen=1 want=no writeback (t=%0t)", $time);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rf_wen", rf_wen, e.rf);
            chk("wb_csr_wen", csr_wen, e.csr);
            chk("wb_trap_en", trap_en, e.trap);
            chk("wb_retired", retired, e.ret);
            chk("wb_state", state, 3);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_flags(input logic ld, input logic st, input logic ec,
                            input logic eb, input logic cs, input logic rd);
      is_load = ld; is_store = st; is_ecall = ec;
      is_ebreak = eb; is_csr = cs; rd_wr = rd;
   endtask

   task automatic expect_wb(input logic rf, input logic cs, input logic tr);
      wb_t e;
      e.rf = rf; e.csr = cs; e.trap = tr; e.ret = exp_ret;
      exp_q.push_back(e);
      exp_ret = exp_ret + 32'd1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      chk("rst_state", state, 0);
      chk("rst_retired", retired, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", err, 0);
      chk("rst_ifu_req_valid", ifu_req_valid, 0);
      chk("rst_lsu_req_valid", lsu_req_valid, 0);
      chk("rst_pc_wen", pc_wen, 0);
      chk("rst_inst_latch_en", inst_latch_en, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      exp_ret = 32'd0;
   endtask

   // Starts at the beginning of a FETCH cycle, ends at the EXEC negedge.
   // With spur=1 rvalid is also driven before/at acceptance and must be ignored.
   task automatic do_fetch(input int waits, input logic spur);
      for (int i = 0; i < waits; i++) begin
         ifu_req_ready = 1'b0; ifu_rvalid = spur;
         at_neg();
         chk("fetch_wait_valid", ifu_req_valid, 1);
         chk("fetch_wait_latch", inst_latch_en, 0);
         cyc();
      end
      ifu_req_ready = 1'b1; ifu_rvalid = spur;
      at_neg();
      chk("fetch_req_valid", ifu_req_valid, 1);
      chk("fetch_acc_latch", inst_latch_en, 0);
      cyc();
      ifu_req_ready = 1'b0; ifu_rvalid = 1'b1;
      at_neg();
      chk("fetch_drop_valid", ifu_req_valid, 0);
      chk("fetch_latch", inst_latch_en, 1);
      chk("fetch_state", state, 0);
      cyc();
      ifu_rvalid = 1'b0;
      at_neg();
      chk("exec_state", state, 1);
      chk("exec_pc_wen", pc_wen, 0);
   endtask

   task automatic run_simple(input int waits, input logic spur, input logic rd,
                             input logic cs, input logic ec);
      set_flags(1'b0, 1'b0, ec, 1'b0, cs, rd);
      expect_wb(rd, cs, ec);
      do_fetch(waits, spur);
      cyc();
      at_neg();
      chk("wb_state_seq", state, 3);
      cyc();
      at_neg();
      chk("post_wb_state", state, 0);
      chk("post_wb_retired", retired, exp_ret);
      chk("post_wb_ifu_req_valid", ifu_req_valid, 1);
      chk("post_wb_rf_wen", rf_wen, 0);
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
   endtask

   // Hard stop in case something wedges the stimulus process.
   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      ifu_req_ready = 1'b0; ifu_rvalid = 1'b0;
      lsu_req_ready = 1'b0; lsu_done = 1'b0;
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_ret = 32'd0;
      #1;
      do_reset();

      // ALU instruction: ready in cycle 1, rvalid in cycle 2, WB in cycle 4.
      run_simple(0, 1'b0, 1'b1, 1'b0, 1'b0);
      // CSR instruction with late ready and spurious early rvalid.
      run_simple(2, 1'b1, 1'b1, 1'b1, 1'b0);

      // Load: ready after 2 cycles, done 3 cycles after that.
      set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_wb(1'b1, 1'b0, 1'b0);
      do_fetch(0, 1'b0);
      cyc();
      for (int i = 0; i < 2; i++) begin
         lsu_req_ready = 1'b0;
         at_neg();
         chk("ld_req_valid", lsu_req_valid, 1);
         chk("ld_wen", lsu_wen, 0);
         chk("ld_state", state, 2);
         cyc();
      end
      lsu_req_ready = 1'b1;
      at_neg();
      chk("ld_req_valid_hs", lsu_req_valid, 1);
      chk("ld_wen_hs", lsu_wen, 0);
      cyc();
      lsu_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         at_neg();
         chk("ld_wait_req_valid", lsu_req_valid, 0);
         chk("ld_wait_state", state, 2);
         cyc();
      end
      lsu_done = 1'b1;
      at_neg();
      chk("ld_done_state", state, 2);
      cyc();
      lsu_done = 1'b0;
      at_neg();
      chk("ld_wb_state", state, 3);
      cyc();
      at_neg();
      chk("ld_post_state", state, 0);
      chk("ld_post_retired", retired, exp_ret);
      cyc();

      // Store: done before acceptance ignored; ready+done together only handshakes.
      set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_wb(1'b0, 1'b0, 1'b0);
      do_fetch(0, 1'b0);
      cyc();
      lsu_req_ready = 1'b0; lsu_done = 1'b1;
      at_neg();
      chk("st_req_valid", lsu_req_valid, 1);
      chk("st_wen", lsu_wen, 1);
      cyc();
      lsu_req_ready = 1'b1; lsu_done = 1'b1;
      at_neg();
      chk("st_early_done_ignored", state, 2);
      chk("st_wen_hs", lsu_wen, 1);
      cyc();
      lsu_req_ready = 1'b0; lsu_done = 1'b0;
      at_neg();
      chk("st_both_high_stays_mem", state, 2);
      chk("st_req_dropped", lsu_req_valid, 0);
      chk("st_wen_dropped", lsu_wen, 0);
      cyc();
      lsu_done = 1'b1;
      at_neg();
      cyc();
      lsu_done = 1'b0;
      at_neg();
      chk("st_wb_state", state, 3);
      cyc();
      at_neg();
      chk("st_post_retired", retired, exp_ret);
      cyc();

      // ecall: trap_en and pc_wen in WB.
      run_simple(0, 1'b0, 1'b0, 1'b0, 1'b1);

      // ebreak (with is_load also set; ebreak has priority) -> sticky HALT.
      set_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      do_fetch(0, 1'b0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         ifu_req_ready = 1'b1;
         at_neg();
         chk("halt_state", state, 4);
         chk("halt_halted", halted, 1);
         chk("halt_ifu_req_valid", ifu_req_valid, 0);
         chk("halt_lsu_req_valid", lsu_req_valid, 0);
         chk("halt_retired", retired, exp_ret);
         cyc();
      end
      ifu_req_ready = 1'b0;
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Watchdog expiry: ready never arrives, ERR after 8 FETCH cycles.
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         at_neg();
         chk("wd_fetch_state", state, 0);
         chk("wd_fetch_err", err, 0);
         cyc();
      end
      at_neg();
      chk("wd_err_state", state, 5);
      chk("wd_err_flag", err, 1);
      chk("wd_err_ifu_req_valid", ifu_req_valid, 0);
      chk("wd_err_halted", halted, 0);
      cyc();
      ifu_req_ready = 1'b1;
      at_neg();
      chk("wd_err_sticky", state, 5);
      chk("wd_err_sticky_req", ifu_req_valid, 0);
      cyc();
      ifu_req_ready = 1'b0;

      // Watchdog boundary: ready on cycle 8 wins over the timeout.
      do_reset();
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_wb(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         at_neg();
         cyc();
      end
      ifu_req_ready = 1'b1;
      at_neg();
      chk("wdb_c8_req_valid", ifu_req_valid, 1);
      cyc();
      ifu_req_ready = 1'b0; ifu_rvalid = 1'b1;
      at_neg();
      chk("wdb_c9_state", state, 0);
      chk("wdb_c9_latch", inst_latch_en, 1);
      cyc();
      ifu_rvalid = 1'b0;
      at_neg();
      chk("wdb_exec_state", state, 1);
      chk("wdb_no_err", err, 0);
      cyc();
      at_neg();
      cyc();
      at_neg();
      chk("wdb_post_retired", retired, 1);
      cyc();

      // Reset mid-MEM with lsu_req_valid asserted.
      set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      do_fetch(0, 1'b0);
      cyc();
      at_neg();
      chk("mr_mem_req_valid", lsu_req_valid, 1);
      chk("mr_mem_state", state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_state", state, 0);
      chk("mr_retired", retired, 0);
      chk("mr_lsu_req_valid", lsu_req_valid, 0);
      chk("mr_ifu_req_valid", ifu_req_valid, 0);
      cyc();
      rst_n = 1'b1;
      exp_ret = 32'd0;
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      at_neg();
      chk("mr_restart_req", ifu_req_valid, 1);
      cyc();

      // Counter wrap from 0xFFFFFFFF.
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      exp_ret = 32'hFFFF_FFFF;
      run_simple(0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wrap_retired", retired, 32'h0000_0000);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
